// File: rtl/v7_peak_detect.sv
// v7_peak_detect: threshold-triggered peak finder for the v7 shaping filter.
// Follows each pulse above THRESHOLD, keeps its maximum sample and the time
// stamp of that maximum, then emits one registered result followed by a
// HOLDOFF dead time.
// Optional macro V7_PEAK_TIMEOUT_EN adds a MAX_WIDTH pulse-length limit that
// forces an emission flagged with peak_timeout; without it peak_timeout is 0.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | waiting for a sample above THRESHOLD
// ARMED    | pulse in progress, tracking maximum / saturation / width
// HOLDOFF  | dead time after an emission, input ignored for HOLDOFF cycles
module v7_peak_detect #(
  parameter int DATA_W    = 16,
  parameter int THRESHOLD = 100,
  parameter int HOLDOFF   = 8,
  parameter int SAT_VAL   = 32767,
  parameter int TS_W      = 32,
  parameter int MAX_WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] filt_data,
  output logic                     peak_valid,
  output logic signed [DATA_W-1:0] peak_amp,
  output logic [TS_W-1:0]          peak_time,
  output logic                     peak_sat,
  output logic                     peak_timeout,
  output logic [15:0]              event_cnt,
  output logic                     busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_HOLDOFF = 2'd2
  } state_t;

  localparam logic signed [DATA_W-1:0] THR_S     = DATA_W'(THRESHOLD);
  localparam logic signed [DATA_W-1:0] SAT_S     = DATA_W'(SAT_VAL);
  localparam logic [7:0]               HOLD_LOAD = 8'(HOLDOFF - 1);

  // Out-of-range parameters would silently break the dead-time or width logic.
  if (HOLDOFF < 1 || HOLDOFF > 255) begin : g_bad_holdoff
    $error("v7_peak_detect: HOLDOFF must be in 1..255");
  end
  if (MAX_WIDTH < 2 || MAX_WIDTH > 65535) begin : g_bad_max_width
    $error("v7_peak_detect: MAX_WIDTH must be in 2..65535");
  end

  state_t                     state_q, state_d;
  logic [TS_W-1:0]            ts_q, ts_d;
  logic signed [DATA_W-1:0]   max_q, max_d;
  logic [TS_W-1:0]            max_ts_q, max_ts_d;
  logic                       sat_q, sat_d;
  logic [7:0]                 hcnt_q, hcnt_d;
  logic                       peak_valid_q, peak_valid_d;
  logic signed [DATA_W-1:0]   peak_amp_q, peak_amp_d;
  logic [TS_W-1:0]            peak_time_q, peak_time_d;
  logic                       peak_sat_q, peak_sat_d;
  logic [15:0]                event_cnt_q, event_cnt_d;
`ifdef V7_PEAK_TIMEOUT_EN
  localparam logic [15:0] WIDTH_LAST = 16'(MAX_WIDTH - 1);
  logic [15:0]                width_q, width_d;
  logic                       peak_timeout_q, peak_timeout_d;
`endif

  logic above_thr;
  logic at_sat;

  assign above_thr = (filt_data > THR_S);
  assign at_sat    = (filt_data >= SAT_S);

  // Next-state and result computation for one sample per clock.
  always_comb begin
    state_d        = state_q;
    ts_d           = ts_q + TS_W'(1);
    max_d          = max_q;
    max_ts_d       = max_ts_q;
    sat_d          = sat_q;
    hcnt_d         = hcnt_q;
    peak_valid_d   = 1'b0;
    peak_amp_d     = peak_amp_q;
    peak_time_d    = peak_time_q;
    peak_sat_d     = peak_sat_q;
    event_cnt_d    = event_cnt_q;
`ifdef V7_PEAK_TIMEOUT_EN
    width_d        = width_q;
    peak_timeout_d = peak_timeout_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (above_thr) begin
          state_d  = S_ARMED;
          max_d    = filt_data;
          max_ts_d = ts_q;
          sat_d    = at_sat;
`ifdef V7_PEAK_TIMEOUT_EN
          width_d  = 16'd1;
`endif
        end
      end

      S_ARMED: begin
        if (!above_thr) begin
          // Falling sample is excluded from the maximum; it also beats a
          // coincident timeout, so peak_timeout is cleared here.
          state_d      = S_HOLDOFF;
          hcnt_d       = HOLD_LOAD;
          peak_valid_d = 1'b1;
          peak_amp_d   = max_q;
          peak_time_d  = max_ts_q;
          peak_sat_d   = sat_q;
          event_cnt_d  = event_cnt_q + 16'd1;
`ifdef V7_PEAK_TIMEOUT_EN
          peak_timeout_d = 1'b0;
`endif
        end else begin
          // Strict compare: on a flat top the first maximum sample is kept.
          if (filt_data > max_q) begin
            max_d    = filt_data;
            max_ts_d = ts_q;
          end
          sat_d = sat_q | at_sat;
`ifdef V7_PEAK_TIMEOUT_EN
          if (width_q == WIDTH_LAST) begin
            // This sample is the MAX_WIDTH-th of the pulse and is still
            // above threshold, so it takes part in the forced result.
            state_d        = S_HOLDOFF;
            hcnt_d         = HOLD_LOAD;
            peak_valid_d   = 1'b1;
            peak_amp_d     = max_d;
            peak_time_d    = max_ts_d;
            peak_sat_d     = sat_d;
            peak_timeout_d = 1'b1;
            event_cnt_d    = event_cnt_q + 16'd1;
          end else begin
            width_d = width_q + 16'd1;
          end
`endif
        end
      end

      S_HOLDOFF: begin
        if (hcnt_q == 8'd0) begin
          state_d = S_IDLE;
        end else begin
          hcnt_d = hcnt_q - 8'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and result registers; synchronous active-low reset wins at any edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      ts_q           <= '0;
      max_q          <= '0;
      max_ts_q       <= '0;
      sat_q          <= 1'b0;
      hcnt_q         <= '0;
      peak_valid_q   <= 1'b0;
      peak_amp_q     <= '0;
      peak_time_q    <= '0;
      peak_sat_q     <= 1'b0;
      event_cnt_q    <= '0;
`ifdef V7_PEAK_TIMEOUT_EN
      width_q        <= '0;
      peak_timeout_q <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      ts_q           <= ts_d;
      max_q          <= max_d;
      max_ts_q       <= max_ts_d;
      sat_q          <= sat_d;
      hcnt_q         <= hcnt_d;
      peak_valid_q   <= peak_valid_d;
      peak_amp_q     <= peak_amp_d;
      peak_time_q    <= peak_time_d;
      peak_sat_q     <= peak_sat_d;
      event_cnt_q    <= event_cnt_d;
`ifdef V7_PEAK_TIMEOUT_EN
      width_q        <= width_d;
      peak_timeout_q <= peak_timeout_d;
`endif
    end
  end

  assign peak_valid = peak_valid_q;
  assign peak_amp   = peak_amp_q;
  assign peak_time  = peak_time_q;
  assign peak_sat   = peak_sat_q;
  assign event_cnt  = event_cnt_q;
  assign busy       = (state_q == S_ARMED) || (state_q == S_HOLDOFF);
`ifdef V7_PEAK_TIMEOUT_EN
  assign peak_timeout = peak_timeout_q;
`else
  assign peak_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_v7_peak_detect.sv
// Bench for v7_peak_detect: directed test-plan streams plus random pulse trains,
// each checked edge by edge against a pulse-scanning reference model.
module tb_v7_peak_detect;

  localparam int THR  = 100;
  localparam int HOLD = 8;
  localparam int SAT  = 32767;
  localparam int MW   = 16;

  logic               clk;
  logic               reset;
  logic signed [15:0] filt_data;
  logic               peak_valid;
  logic signed [15:0] peak_amp;
  logic [31:0]        peak_time;
  logic               peak_sat;
  logic               peak_timeout;
  logic [15:0]        event_cnt;
  logic               busy;

  typedef struct packed {
    logic        valid;
    logic [15:0] amp;
    logic [31:0] tim;
    logic        sat;
    logic        tmo;
    logic [15:0] cnt;
    logic        busy;
  } obs_t;

  obs_t obs_a[1024];
  obs_t exp_a[1024];
  int   n_checks = 0;
  int   n_pass   = 0;

  v7_peak_detect #(
    .DATA_W(16), .THRESHOLD(THR), .HOLDOFF(HOLD),
    .SAT_VAL(SAT), .TS_W(32), .MAX_WIDTH(MW)
  ) dut (
    .clk(clk), .reset(reset), .filt_data(filt_data),
    .peak_valid(peak_valid), .peak_amp(peak_amp), .peak_time(peak_time),
    .peak_sat(peak_sat), .peak_timeout(peak_timeout),
    .event_cnt(event_cnt), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running want done");
    $fatal(1);
  end

  function automatic string fmt(input obs_t o);
    return $sformatf("v=%0d amp=%0d t=%0d sat=%0d to=%0d cnt=%0d busy=%0d",
                     o.valid, $signed(o.amp), o.tim, o.sat, o.tmo, o.cnt, o.busy);
  endfunction

  function automatic obs_t sample_dut();
    return {peak_valid, peak_amp, peak_time, peak_sat, peak_timeout, event_cnt, busy};
  endfunction

  // Drive one sample per edge, recording outputs #1 after each edge.
  // Edge index k sees ts = k when the stream starts right after reset.
  task automatic drive(input int s[$], input bit do_reset);
    int v;
    if (do_reset) begin
      reset = 1'b0; filt_data = '0;
      @(posedge clk); #1;
      reset = 1'b1;
    end
    for (int k = 0; k < s.size(); k++) begin
      v = s[k];
      filt_data = v[15:0];
      @(posedge clk); #1;
      obs_a[k] = sample_dut();
    end
  endtask

  // Reference: scan the stream for pulses, find each pulse's end (first
  // sample not above THR, or the MW-th sample when the timeout is built),
  // then skip HOLD samples of dead time before looking for the next pulse.
  task automatic build_model(input int s[$]);
    int n, k, fin, mx, mt, len, last_busy, cnt;
    bit sat, tmo;
    obs_t held;
    n = s.size();
    for (int i = 0; i < n; i++) exp_a[i] = '0;
    k = 0;
    while (k < n) begin
      if (s[k] <= THR) begin
        k++;
        continue;
      end
      mx = s[k]; mt = k; sat = (s[k] >= SAT); len = 1; tmo = 0; fin = -1;
      for (int j = k + 1; j < n; j++) begin
        if (s[j] <= THR) begin fin = j; break; end
        if (s[j] > mx) begin mx = s[j]; mt = j; end
        if (s[j] >= SAT) sat = 1;
        len++;
`ifdef V7_PEAK_TIMEOUT_EN
        if (len == MW) begin fin = j; tmo = 1; break; end
`endif
      end
      last_busy = (fin < 0) ? n - 1 : fin + HOLD - 1;
      for (int i = k; i <= last_busy && i < n; i++) exp_a[i].busy = 1'b1;
      if (fin < 0) break;
      exp_a[fin].valid = 1'b1;
      exp_a[fin].amp   = 16'(mx);
      exp_a[fin].tim   = 32'(mt);
      exp_a[fin].sat   = sat;
      exp_a[fin].tmo   = tmo;
      k = fin + HOLD + 1;
    end
    held = '0; cnt = 0;
    for (int i = 0; i < n; i++) begin
      if (exp_a[i].valid) begin
        cnt++;
        held.amp = exp_a[i].amp; held.tim = exp_a[i].tim;
        held.sat = exp_a[i].sat; held.tmo = exp_a[i].tmo;
      end
      exp_a[i].amp = held.amp; exp_a[i].tim = held.tim;
      exp_a[i].sat = held.sat; exp_a[i].tmo = held.tmo;
      exp_a[i].cnt = 16'(cnt);
    end
  endtask

  task automatic test_reset();
    obs_t o;
    reset = 1'b0; filt_data = 16'sd300;
    @(posedge clk); #1;
    o = sample_dut();
    n_checks++;
    if (o !== '0) $display("FAIL reset_state: got %s want all zero", fmt(o));
    else n_pass++;
    reset = 1'b1;
  endtask

  task automatic test_basic();
    int q[$];
    q = {0, 50, 150, 300, 450, 300, 150, 90};
    repeat (12) q.push_back(0);
    build_model(q); drive(q, 1'b1);
    for (int k = 0; k < q.size(); k++) begin
      n_checks++;
      if (obs_a[k] !== exp_a[k])
        $display("FAIL basic edge %0d: got %s want %s", k, fmt(obs_a[k]), fmt(exp_a[k]));
      else n_pass++;
    end
    n_checks++;
    if (obs_a[7].amp !== 16'd450 || obs_a[7].tim !== 32'd4 || obs_a[7].cnt !== 16'd1)
      $display("FAIL basic_plan: got %s want amp=450 t=4 cnt=1", fmt(obs_a[7]));
    else n_pass++;
  endtask

  task automatic test_flat_top();
    int q[$];
    q = {200, 500, 500, 500, 80};
    repeat (10) q.push_back(0);
    build_model(q); drive(q, 1'b1);
    for (int k = 0; k < q.size(); k++) begin
      n_checks++;
      if (obs_a[k] !== exp_a[k])
        $display("FAIL flat_top edge %0d: got %s want %s", k, fmt(obs_a[k]), fmt(exp_a[k]));
      else n_pass++;
    end
  endtask

  task automatic test_holdoff();
    int q[$];
    q = {0, 300, 50};
    repeat (20) q.push_back(300);
    q.push_back(50);
    repeat (10) q.push_back(0);
    build_model(q); drive(q, 1'b1);
    for (int k = 0; k < q.size(); k++) begin
      n_checks++;
      if (obs_a[k] !== exp_a[k])
        $display("FAIL holdoff edge %0d: got %s want %s", k, fmt(obs_a[k]), fmt(exp_a[k]));
      else n_pass++;
    end
  endtask

  task automatic test_saturation();
    int q[$];
    q = {0, 20000, 32767, 32767, 10};
    repeat (10) q.push_back(0);
    build_model(q); drive(q, 1'b1);
    for (int k = 0; k < q.size(); k++) begin
      n_checks++;
      if (obs_a[k] !== exp_a[k])
        $display("FAIL saturation edge %0d: got %s want %s", k, fmt(obs_a[k]), fmt(exp_a[k]));
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_pulse();
    int q[$];
    obs_t o;
    q = {0, 300, 50};
    repeat (HOLD + 2) q.push_back(0);
    q.push_back(400); q.push_back(400);
    drive(q, 1'b1);
    reset = 1'b0; filt_data = 16'sd400;
    @(posedge clk); #1;
    o = sample_dut();
    n_checks++;
    if (o !== '0) $display("FAIL reset_mid_pulse: got %s want all zero", fmt(o));
    else n_pass++;
    reset = 1'b1;
    q = {0, 0, 250, 60};
    repeat (12) q.push_back(0);
    build_model(q); drive(q, 1'b0);
    for (int k = 0; k < q.size(); k++) begin
      n_checks++;
      if (obs_a[k] !== exp_a[k])
        $display("FAIL after_reset edge %0d: got %s want %s", k, fmt(obs_a[k]), fmt(exp_a[k]));
      else n_pass++;
    end
  endtask

  task automatic test_timeout();
    int q[$];
    repeat (30) q.push_back(200);
    repeat (12) q.push_back(0);
    build_model(q); drive(q, 1'b1);
    for (int k = 0; k < q.size(); k++) begin
      n_checks++;
      if (obs_a[k] !== exp_a[k])
        $display("FAIL timeout edge %0d: got %s want %s", k, fmt(obs_a[k]), fmt(exp_a[k]));
      else n_pass++;
    end
  endtask

  task automatic test_random(input int iter);
    int q[$];
    int sel;
    q = {};
    while (q.size() < 300) begin
      repeat ($urandom_range(0, 12)) begin
        sel = $urandom_range(0, 5);
        if (sel == 0)      q.push_back(THR);
        else if (sel == 1) q.push_back(-32768);
        else               q.push_back(int'($urandom_range(0, 400)) - 300);
      end
      repeat ($urandom_range(1, 40)) begin
        sel = $urandom_range(0, 9);
        if (sel == 0)      q.push_back(SAT);
        else if (sel == 1) q.push_back(THR + 1);
        else               q.push_back(int'($urandom_range(THR + 1, 32000)));
      end
    end
    repeat (HOLD + 4) q.push_back(0);
    build_model(q); drive(q, 1'b1);
    for (int k = 0; k < q.size(); k++) begin
      n_checks++;
      if (obs_a[k] !== exp_a[k])
        $display("FAIL random%0d edge %0d: got %s want %s", iter, k, fmt(obs_a[k]), fmt(exp_a[k]));
      else n_pass++;
    end
  endtask

  initial begin
    reset = 1'b0;
    filt_data = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_flat_top();
    test_holdoff();
    test_saturation();
    test_reset_mid_pulse();
    test_timeout();
    for (int i = 0; i < 4; i++) test_random(i);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
